// File: rtl/key_conditioner.sv
// Per-key synchroniser, debouncer and hold-timer for active-low pushbuttons.
// Each channel produces a clean level plus single-cycle press/release/long/repeat pulses.
module key_conditioner #(
  parameter int NUM_KEYS        = 2,
  parameter int CNT_W           = 26,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic [NUM_KEYS-1:0]   KEY,
  output logic [NUM_KEYS-1:0]   key_level,
  output logic [NUM_KEYS-1:0]   key_press,
  output logic [NUM_KEYS-1:0]   key_release,
  output logic [NUM_KEYS-1:0]   key_long,
  output logic [NUM_KEYS-1:0]   key_repeat,
  output logic [3*NUM_KEYS-1:0] key_state
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    HELD         = 3'd2,
    LONG_HELD    = 3'd3,
    RELEASE_WAIT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic             s1;
    logic             s2;
    logic             long_flag;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             long_q;
    logic             repeat_q;
    logic [CNT_W-1:0] cnt;
    state_t           state;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        s1        <= 1'b1;
        s2        <= 1'b1;
        state     <= IDLE;
        cnt       <= '0;
        long_flag <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        s1        <= KEY[k];
        s2        <= s1;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
        case (state)
          IDLE: begin
            if (!s2) begin
              state <= PRESS_WAIT;
              cnt   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (s2) begin
              state <= IDLE;
            end else if (cnt == DEB_LAST) begin
              state   <= HELD;
              cnt     <= '0;
              press_q <= 1'b1;
              level_q <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          HELD: begin
            if (s2) begin
              state <= RELEASE_WAIT;
              cnt   <= '0;
            end else if (cnt == LONG_LAST) begin
              state     <= LONG_HELD;
              cnt       <= '0;
              long_flag <= 1'b1;
              long_q    <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          LONG_HELD: begin
            if (s2) begin
              state <= RELEASE_WAIT;
              cnt   <= '0;
            end else if (cnt == REP_LAST) begin
              repeat_q <= 1'b1;
              cnt      <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          RELEASE_WAIT: begin
            // A short high blip while held is treated as contact chatter;
            // the hold timer restarts but the key stays logically pressed.
            if (!s2) begin
              state <= long_flag ? LONG_HELD : HELD;
              cnt   <= '0;
            end else if (cnt == DEB_LAST) begin
              state     <= IDLE;
              level_q   <= 1'b0;
              release_q <= 1'b1;
              long_flag <= 1'b0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign key_level[k]       = level_q;
    assign key_press[k]       = press_q;
    assign key_release[k]     = release_q;
    assign key_long[k]        = long_q;
    assign key_repeat[k]      = repeat_q;
    assign key_state[3*k +: 3] = state;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: scenario tasks with explicit timing checks plus a
// run-length reference model compared against every output on every cycle.
module tb_key_conditioner;

  localparam int NK   = 2;
  localparam int DEB  = 4;
  localparam int LNG  = 20;
  localparam int REP  = 6;

  logic          CLOCK_50;
  logic          RESET_N;
  logic [NK-1:0] KEY;
  logic [NK-1:0] key_level, key_press, key_release, key_long, key_repeat;
  logic [3*NK-1:0] key_state;

  key_conditioner #(
    .NUM_KEYS(NK), .CNT_W(8), .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES(LNG), .REPEAT_CYCLES(REP)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .KEY(KEY),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .key_repeat(key_repeat), .key_state(key_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // clock / reset
  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  initial forever begin
    @(posedge CLOCK_50);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Reference model: a key is accepted after DEB+1 consecutive samples of the
  // new level at the FSM input (two flops behind KEY); hold age counts edges
  // since the last press or chatter recovery.
  logic [NK-1:0] exp_level, exp_press, exp_release, exp_long, exp_repeat;
  bit m_s1[NK], m_s2[NK], m_long[NK];
  int m_run[NK], m_age[NK];

  task automatic model_clear();
    exp_level = '0; exp_press = '0; exp_release = '0; exp_long = '0; exp_repeat = '0;
    for (int k = 0; k < NK; k++) begin
      m_s1[k] = 1'b1; m_s2[k] = 1'b1; m_long[k] = 1'b0; m_run[k] = 0; m_age[k] = 0;
    end
  endtask

  task automatic model_step();
    exp_press = '0; exp_release = '0; exp_long = '0; exp_repeat = '0;
    for (int k = 0; k < NK; k++) begin
      bit pressed;
      pressed = !m_s2[k];
      m_s2[k] = m_s1[k];
      m_s1[k] = KEY[k];
      if (!exp_level[k]) begin
        if (pressed) begin
          m_run[k]++;
          if (m_run[k] == DEB + 1) begin
            exp_level[k] = 1'b1; exp_press[k] = 1'b1; m_run[k] = 0; m_age[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
      end else if (!pressed) begin
        m_run[k]++;
        if (m_run[k] == DEB + 1) begin
          exp_level[k] = 1'b0; exp_release[k] = 1'b1; m_run[k] = 0; m_long[k] = 1'b0;
        end
      end else if (m_run[k] > 0) begin
        m_run[k] = 0;
        m_age[k] = 0;
      end else begin
        m_age[k]++;
        if (!m_long[k] && m_age[k] == LNG) begin
          exp_long[k] = 1'b1; m_long[k] = 1'b1; m_age[k] = 0;
        end else if (m_long[k] && m_age[k] == REP) begin
          exp_repeat[k] = 1'b1; m_age[k] = 0;
        end
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge CLOCK_50 or negedge RESET_N);
      if (!RESET_N) model_clear();
      else model_step();
    end
  end

  // scenarios
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK_50);
      n_tests++;
      if ({key_level, key_press, key_release, key_long, key_repeat} !== 10'b0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d got=%b required=0", cyc,
                 {key_level, key_press, key_release, key_long, key_repeat});
      end
    end
    RESET_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK_50);
      n_tests++;
      if ({key_level, key_press, key_release, key_long, key_repeat} !== 10'b0) begin
        n_fail++;
        $display("FAIL idle_after_reset cyc=%0d got=%b required=0", cyc,
                 {key_level, key_press, key_release, key_long, key_repeat});
      end
    end
  endtask

  task automatic test_clean();
    int c0;
    int pq[$], rq[$], lq[$];
    bit level_ok;
    level_ok = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 24; i++) begin
      KEY[0] = (i < 12) ? 1'b0 : 1'b1;
      @(negedge CLOCK_50);
      n_tests++;
      if ({key_level, key_press, key_release, key_long, key_repeat} !==
          {exp_level, exp_press, exp_release, exp_long, exp_repeat}) begin
        n_fail++;
        $display("FAIL clean_model cyc=%0d got=%b required=%b", cyc,
                 {key_level, key_press, key_release, key_long, key_repeat},
                 {exp_level, exp_press, exp_release, exp_long, exp_repeat});
      end
      if (key_press[0]) pq.push_back(cyc);
      if (key_release[0]) rq.push_back(cyc);
      if (key_long[0]) lq.push_back(cyc);
      if (key_level[0] !== ((cyc >= c0 + 7) && (cyc <= c0 + 18))) level_ok = 1'b0;
    end
    n_tests++;
    if (pq.size() != 1 || pq[0] != c0 + 7) begin
      n_fail++; $display("FAIL clean_press count=%0d first=%0d required=1@%0d", pq.size(),
                         (pq.size() > 0) ? pq[0] : -1, c0 + 7);
    end
    n_tests++;
    if (rq.size() != 1 || rq[0] != c0 + 19) begin
      n_fail++; $display("FAIL clean_release count=%0d first=%0d required=1@%0d", rq.size(),
                         (rq.size() > 0) ? rq[0] : -1, c0 + 19);
    end
    n_tests++;
    if (lq.size() != 0 || !level_ok) begin
      n_fail++; $display("FAIL clean_level_long longs=%0d level_ok=%0d required 0/1",
                         lq.size(), level_ok);
    end
  endtask

  task automatic test_bounce();
    int c0;
    int pq[$], rq[$];
    c0 = cyc;
    for (int i = 0; i < 33; i++) begin
      KEY[0] = !((i < 3) || (i >= 4 && i < 6) || (i >= 7 && i < 21));
      @(negedge CLOCK_50);
      n_tests++;
      if ({key_level, key_press, key_release, key_long, key_repeat} !==
          {exp_level, exp_press, exp_release, exp_long, exp_repeat}) begin
        n_fail++;
        $display("FAIL bounce_model cyc=%0d got=%b required=%b", cyc,
                 {key_level, key_press, key_release, key_long, key_repeat},
                 {exp_level, exp_press, exp_release, exp_long, exp_repeat});
      end
      if (key_press[0]) pq.push_back(cyc);
      if (key_release[0]) rq.push_back(cyc);
    end
    n_tests++;
    if (pq.size() != 1 || pq[0] != c0 + 14) begin
      n_fail++; $display("FAIL bounce_press count=%0d first=%0d required=1@%0d", pq.size(),
                         (pq.size() > 0) ? pq[0] : -1, c0 + 14);
    end
    n_tests++;
    if (rq.size() != 1 || rq[0] != c0 + 28) begin
      n_fail++; $display("FAIL bounce_release count=%0d first=%0d required=1@%0d", rq.size(),
                         (rq.size() > 0) ? rq[0] : -1, c0 + 28);
    end
  endtask

  task automatic test_long_repeat();
    int c0;
    int pq[$], rq[$], lq[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    c0 = cyc;
    for (int k = 1; k <= 5; k++) exp_q.push_back(32'(c0 + 27 + k * REP));
    for (int i = 0; i < 72; i++) begin
      KEY[1] = (i < 60) ? 1'b0 : 1'b1;
      @(negedge CLOCK_50);
      n_tests++;
      if ({key_level, key_press, key_release, key_long, key_repeat} !==
          {exp_level, exp_press, exp_release, exp_long, exp_repeat}) begin
        n_fail++;
        $display("FAIL long_model cyc=%0d got=%b required=%b", cyc,
                 {key_level, key_press, key_release, key_long, key_repeat},
                 {exp_level, exp_press, exp_release, exp_long, exp_repeat});
      end
      if (key_press[1]) pq.push_back(cyc);
      if (key_release[1]) rq.push_back(cyc);
      if (key_long[1]) lq.push_back(cyc);
      if (key_repeat[1]) got_q.push_back(32'(cyc));
    end
    n_tests++;
    if (pq.size() != 1 || pq[0] != c0 + 7 || lq.size() != 1 || lq[0] != c0 + 27) begin
      n_fail++; $display("FAIL long_time press=%0d long=%0d/%0d required %0d/%0d", pq.size(),
                         lq.size(), (lq.size() > 0) ? lq[0] : -1, c0 + 7, c0 + 27);
    end
    n_tests++;
    if (got_q != exp_q) begin
      n_fail++; $display("FAIL repeat_times got=%p required=%p", got_q, exp_q);
    end
    n_tests++;
    if (rq.size() != 1 || rq[0] != c0 + 67) begin
      n_fail++; $display("FAIL long_release count=%0d required=1@%0d", rq.size(), c0 + 67);
    end
  endtask

  task automatic test_glitch();
    int c0;
    int pq[$], rq[$], lq[$];
    bit level_ok;
    level_ok = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 56; i++) begin
      KEY[0] = (i == 10 || i == 11 || i >= 40);
      @(negedge CLOCK_50);
      n_tests++;
      if ({key_level, key_press, key_release, key_long, key_repeat} !==
          {exp_level, exp_press, exp_release, exp_long, exp_repeat}) begin
        n_fail++;
        $display("FAIL glitch_model cyc=%0d got=%b required=%b", cyc,
                 {key_level, key_press, key_release, key_long, key_repeat},
                 {exp_level, exp_press, exp_release, exp_long, exp_repeat});
      end
      if (key_press[0]) pq.push_back(cyc);
      if (key_release[0]) rq.push_back(cyc);
      if (key_long[0]) lq.push_back(cyc);
      if (cyc >= c0 + 7 && cyc <= c0 + 46 && key_level[0] !== 1'b1) level_ok = 1'b0;
    end
    n_tests++;
    if (pq.size() != 1 || !level_ok || rq.size() != 1 || rq[0] != c0 + 47) begin
      n_fail++; $display("FAIL glitch_level press=%0d release=%0d level_ok=%0d required 1/1@%0d/1",
                         pq.size(), rq.size(), level_ok, c0 + 47);
    end
    n_tests++;
    if (lq.size() != 1 || lq[0] != c0 + 35) begin
      n_fail++; $display("FAIL glitch_long count=%0d at=%0d required=1@%0d", lq.size(),
                         (lq.size() > 0) ? lq[0] : -1, c0 + 35);
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    int pq[$], rq[$];
    c0 = cyc;
    for (int i = 0; i < 64; i++) begin
      KEY[1] = (i < 50) ? 1'b0 : 1'b1;
      @(negedge CLOCK_50);
      n_tests++;
      if ({key_level, key_press, key_release, key_long, key_repeat} !==
          {exp_level, exp_press, exp_release, exp_long, exp_repeat}) begin
        n_fail++;
        $display("FAIL resetmid_model cyc=%0d got=%b required=%b", cyc,
                 {key_level, key_press, key_release, key_long, key_repeat},
                 {exp_level, exp_press, exp_release, exp_long, exp_repeat});
      end
      if (key_press[1]) pq.push_back(cyc);
      if (key_release[1]) rq.push_back(cyc);
      if (i == 29) begin
        n_tests++;
        if (key_level[1] !== 1'b1) begin
          n_fail++; $display("FAIL resetmid_pre level=%b required=1", key_level[1]);
        end
        RESET_N = 1'b0;
        #1;
        n_tests++;
        if ({key_level, key_press, key_release, key_long, key_repeat} !== 10'b0) begin
          n_fail++; $display("FAIL reset_async got=%b required=0",
                             {key_level, key_press, key_release, key_long, key_repeat});
        end
      end
      if (i == 31) RESET_N = 1'b1;
    end
    n_tests++;
    if (pq.size() != 2 || pq[0] != c0 + 7 || pq[1] != c0 + 39) begin
      n_fail++; $display("FAIL resetmid_press count=%0d second=%0d required=2 with %0d",
                         pq.size(), (pq.size() > 1) ? pq[1] : -1, c0 + 39);
    end
    n_tests++;
    if (rq.size() != 1 || rq[0] != c0 + 57) begin
      n_fail++; $display("FAIL resetmid_release count=%0d required=1@%0d", rq.size(), c0 + 57);
    end
  endtask

  task automatic test_independence();
    int c0;
    int pq0[$], pq1[$], lq0[$], lq1[$], rq0[$], rq1[$];
    c0 = cyc;
    for (int i = 0; i < 64; i++) begin
      KEY[0] = !((i < 10) || (i >= 20 && i < 50));
      KEY[1] = !((i < 10) || (i >= 23 && i < 50));
      @(negedge CLOCK_50);
      n_tests++;
      if ({key_level, key_press, key_release, key_long, key_repeat} !==
          {exp_level, exp_press, exp_release, exp_long, exp_repeat}) begin
        n_fail++;
        $display("FAIL indep_model cyc=%0d got=%b required=%b", cyc,
                 {key_level, key_press, key_release, key_long, key_repeat},
                 {exp_level, exp_press, exp_release, exp_long, exp_repeat});
      end
      if (key_press[0]) pq0.push_back(cyc);
      if (key_press[1]) pq1.push_back(cyc);
      if (key_long[0]) lq0.push_back(cyc);
      if (key_long[1]) lq1.push_back(cyc);
      if (key_release[0]) rq0.push_back(cyc);
      if (key_release[1]) rq1.push_back(cyc);
    end
    n_tests++;
    if (pq0.size() != 2 || pq1.size() != 2 || pq0[0] != c0 + 7 || pq1[0] != c0 + 7 ||
        pq0[1] != c0 + 27 || pq1[1] != c0 + 30) begin
      n_fail++; $display("FAIL indep_press k0=%p k1=%p required [%0d,%0d] [%0d,%0d]",
                         pq0, pq1, c0 + 7, c0 + 27, c0 + 7, c0 + 30);
    end
    n_tests++;
    if (lq0.size() != 1 || lq1.size() != 1 || lq0[0] != c0 + 47 || lq1[0] != c0 + 50) begin
      n_fail++; $display("FAIL indep_long k0=%p k1=%p required %0d %0d",
                         lq0, lq1, c0 + 47, c0 + 50);
    end
    n_tests++;
    if (rq0.size() != 2 || rq1.size() != 2 || rq0[0] != c0 + 17 || rq1[1] != c0 + 57) begin
      n_fail++; $display("FAIL indep_release k0=%p k1=%p required [%0d,%0d]",
                         rq0, rq1, c0 + 17, c0 + 57);
    end
  endtask

  task automatic test_random();
    int left[NK];
    for (int k = 0; k < NK; k++) left[k] = $urandom_range(1, 30);
    for (int i = 0; i < 512; i++) begin
      for (int k = 0; k < NK; k++) begin
        left[k]--;
        if (left[k] == 0) begin
          KEY[k] = ~KEY[k];
          left[k] = $urandom_range(1, 30);
        end
      end
      if (i >= 500) KEY = '1;
      @(negedge CLOCK_50);
      n_tests++;
      if ({key_level, key_press, key_release, key_long, key_repeat} !==
          {exp_level, exp_press, exp_release, exp_long, exp_repeat}) begin
        n_fail++;
        $display("FAIL random_model cyc=%0d got=%b required=%b", cyc,
                 {key_level, key_press, key_release, key_long, key_repeat},
                 {exp_level, exp_press, exp_release, exp_long, exp_repeat});
      end
    end
  endtask

  initial begin
    RESET_N = 1'b0;
    KEY     = '1;
    test_reset();
    test_clean();
    test_bounce();
    test_long_repeat();
    test_glitch();
    test_reset_mid();
    test_independence();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
